// File: rtl/mips_debug_unit_pkg.sv
// Shared command bytes, FSM encodings and sizing helpers for the MIPS
// debug/loader front-end.
package mips_debug_unit_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
  localparam logic [7:0] CMD_DUMP  = 8'h44;  // 'D'
  localparam logic [7:0] CMD_PAUSE = 8'h50;  // 'P'
  localparam logic [7:0] ACK_BYTE  = 8'h4B;  // 'K'

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_CNT,
    ST_LOAD_BYTE,
    ST_LOAD_WRITE,
    ST_ACK,
    ST_RUN,
    ST_STEP,
    ST_DUMP_ADDR,
    ST_DUMP_LATCH,
    ST_TX_BYTE,
    ST_TX_WAIT
  } state_t;

  // Which section of the dump stream is being sent.
  typedef enum logic [1:0] {
    PH_PC,
    PH_REG,
    PH_MEM
  } dump_phase_t;

  // clog2 that never returns 0, so single-entry counters still get a bit.
  function automatic int clog2c(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mips_debug_unit_if.sv
// Bundle of UART-side and CPU-side signals around the debug unit.
interface mips_debug_unit_if
  import mips_debug_unit_pkg::*;
#(
  parameter int NBITS      = 32,
  parameter int REGS       = 5,
  parameter int IMEM_DEPTH = 256,
  parameter int MEM_AW     = 7
);
  localparam int IMEM_AW = clog2c(IMEM_DEPTH);

  // Handshakes: rx_valid, tx_start, tx_done and imem_we are one-cycle strobes.
  // rx_data is only meaningful while rx_valid is high and there is no ready
  // (bytes arriving when the unit cannot take them are dropped); tx_start is
  // never raised again until tx_done has been seen for the previous byte.
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_done;
  logic               cpu_enable;
  logic               cpu_halt;
  logic [NBITS-1:0]   cpu_pc;
  logic [REGS-1:0]    reg_addr;
  logic [NBITS-1:0]   reg_data;
  logic [MEM_AW-1:0]  mem_addr;
  logic [NBITS-1:0]   mem_data;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [NBITS-1:0]   imem_wdata;
  logic               busy;
  state_t             dbg_state;

  modport master (
    input  rx_data, rx_valid, tx_done, cpu_halt, cpu_pc, reg_data, mem_data,
    output tx_data, tx_start, cpu_enable, reg_addr, mem_addr,
           imem_we, imem_addr, imem_wdata, busy, dbg_state
  );

  modport slave (
    output rx_data, rx_valid, tx_done, cpu_halt, cpu_pc, reg_data, mem_data,
    input  tx_data, tx_start, cpu_enable, reg_addr, mem_addr,
           imem_we, imem_addr, imem_wdata, busy, dbg_state
  );

endinterface

// File: rtl/mips_debug_unit_dbg_word_serializer.sv
// Holds one dump word and presents it a byte at a time, MSB first; the
// owner advances it once per completed TX byte.
module dbg_word_serializer
  import mips_debug_unit_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [NBITS-1:0] word,
  input  logic             advance,
  output logic [7:0]       tx_byte,
  output logic             last
);
  localparam int BYTES = NBITS / 8;
  localparam int BW    = clog2c(BYTES);

  logic [NBITS-1:0] shreg;
  logic [BW-1:0]    byte_idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg    <= '0;
      byte_idx <= '0;
    end else if (load) begin
      shreg    <= word;
      byte_idx <= '0;
    end else if (advance && !last) begin
      shreg    <= shreg << 8;
      byte_idx <= byte_idx + 1'b1;
    end
  end

  assign tx_byte = shreg[NBITS-1 -: 8];
  assign last    = (byte_idx == BW'(BYTES - 1));

endmodule

// File: rtl/mips_debug_unit.sv
// Debug/loader front-end: decodes UART command bytes, loads instruction
// memory, gates the CPU clock-enable and streams PC/regs/memory back out.
module mips_debug_unit
  import mips_debug_unit_pkg::*;
#(
  parameter int NBITS      = 32,
  parameter int CELDAS_REG = 32,
  parameter int CELDAS_M   = 70,
  parameter int REGS       = 5,
  parameter int IMEM_DEPTH = 256,
  parameter int MEM_AW     = 7
) (
  input logic              clk,
  input logic              reset,
  mips_debug_unit_if.master bus
);
  localparam int BYTES   = NBITS / 8;
  localparam int BW      = clog2c(BYTES);
  localparam int IMEM_AW = clog2c(IMEM_DEPTH);
  localparam int DMAX    = (CELDAS_REG > CELDAS_M) ? CELDAS_REG : CELDAS_M;
  localparam int DIDX_W  = clog2c(DMAX);

  state_t             state, state_next;
  logic [7:0]         word_cnt;
  logic [BW-1:0]      byte_cnt;
  logic [NBITS-1:0]   asm_word;
  logic [IMEM_AW-1:0] load_addr;
  dump_phase_t        phase;
  logic [DIDX_W-1:0]  didx;
  logic               ack_mode;

  logic               cpu_enable_c, tx_start_c, imem_we_c;
  logic               ser_load, ser_adv, ser_last;
  logic [7:0]         ser_byte;
  logic [NBITS-1:0]   ser_word;
  logic               dump_last_word;

  assign dump_last_word = (phase == PH_MEM) && (didx == DIDX_W'(CELDAS_M - 1));

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    cpu_enable_c = 1'b0;
    tx_start_c   = 1'b0;
    imem_we_c    = 1'b0;
    ser_load     = 1'b0;
    ser_adv      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            CMD_LOAD: state_next = ST_LOAD_CNT;
            CMD_STEP: state_next = ST_STEP;
            CMD_RUN:  state_next = ST_RUN;
            CMD_DUMP: state_next = ST_DUMP_ADDR;
            default:  state_next = ST_IDLE;
          endcase
        end
      end
      ST_LOAD_CNT: begin
        if (bus.rx_valid)
          state_next = (bus.rx_data == 8'd0) ? ST_IDLE : ST_LOAD_BYTE;
      end
      ST_LOAD_BYTE: begin
        if (bus.rx_valid && byte_cnt == BW'(BYTES - 1))
          state_next = ST_LOAD_WRITE;
      end
      ST_LOAD_WRITE: begin
        imem_we_c  = 1'b1;
        state_next = (word_cnt == 8'd1) ? ST_ACK : ST_LOAD_BYTE;
      end
      ST_ACK: begin
        tx_start_c = 1'b1;
        state_next = ST_TX_WAIT;
      end
      ST_RUN: begin
        // Halt gates the enable combinationally so the halting cycle is
        // never itself enabled; it also takes priority over a pause byte.
        cpu_enable_c = !bus.cpu_halt;
        if (bus.cpu_halt || (bus.rx_valid && bus.rx_data == CMD_PAUSE))
          state_next = ST_DUMP_ADDR;
      end
      ST_STEP: begin
        cpu_enable_c = 1'b1;
        state_next   = ST_DUMP_ADDR;
      end
      ST_DUMP_ADDR:  state_next = ST_DUMP_LATCH;
      ST_DUMP_LATCH: begin
        ser_load   = 1'b1;
        state_next = ST_TX_BYTE;
      end
      ST_TX_BYTE: begin
        tx_start_c = 1'b1;
        state_next = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (bus.tx_done) begin
          if (ack_mode) begin
            state_next = ST_IDLE;
          end else if (!ser_last) begin
            ser_adv    = 1'b1;
            state_next = ST_TX_BYTE;
          end else begin
            state_next = dump_last_word ? ST_IDLE : ST_DUMP_ADDR;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Load/dump bookkeeping; everything clears on reset so a half-built word
  // or an abandoned dump leaves no trace.
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_cnt  <= '0;
      byte_cnt  <= '0;
      asm_word  <= '0;
      load_addr <= '0;
      phase     <= PH_PC;
      didx      <= '0;
      ack_mode  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack_mode <= 1'b0;
          phase    <= PH_PC;
          didx     <= '0;
          if (bus.rx_valid && bus.rx_data == CMD_LOAD) load_addr <= '0;
        end
        ST_LOAD_CNT: begin
          if (bus.rx_valid) begin
            word_cnt <= bus.rx_data;
            byte_cnt <= '0;
          end
        end
        ST_LOAD_BYTE: begin
          if (bus.rx_valid) begin
            asm_word <= NBITS'({asm_word, bus.rx_data});
            byte_cnt <= (byte_cnt == BW'(BYTES - 1)) ? '0 : byte_cnt + 1'b1;
          end
        end
        ST_LOAD_WRITE: begin
          word_cnt  <= word_cnt - 8'd1;
          load_addr <= (load_addr == IMEM_AW'(IMEM_DEPTH - 1)) ? '0 : load_addr + 1'b1;
        end
        ST_ACK: ack_mode <= 1'b1;
        ST_TX_WAIT: begin
          if (bus.tx_done && !ack_mode && ser_last) begin
            case (phase)
              PH_PC: begin
                phase <= PH_REG;
                didx  <= '0;
              end
              PH_REG: begin
                if (didx == DIDX_W'(CELDAS_REG - 1)) begin
                  phase <= PH_MEM;
                  didx  <= '0;
                end else begin
                  didx <= didx + 1'b1;
                end
              end
              default: didx <= didx + 1'b1;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ser_word = bus.mem_data;
    case (phase)
      PH_PC:   ser_word = bus.cpu_pc;
      PH_REG:  ser_word = bus.reg_data;
      default: ser_word = bus.mem_data;
    endcase
  end

  dbg_word_serializer #(.NBITS(NBITS)) u_ser (
    .clk     (clk),
    .reset   (reset),
    .load    (ser_load),
    .word    (ser_word),
    .advance (ser_adv),
    .tx_byte (ser_byte),
    .last    (ser_last)
  );

  assign bus.tx_data    = (state == ST_ACK || ack_mode) ? ACK_BYTE : ser_byte;
  assign bus.tx_start   = tx_start_c;
  assign bus.cpu_enable = cpu_enable_c;
  assign bus.reg_addr   = (phase == PH_REG) ? REGS'(didx) : '0;
  assign bus.mem_addr   = (phase == PH_MEM) ? MEM_AW'(didx) : '0;
  assign bus.imem_we    = imem_we_c;
  assign bus.imem_addr  = load_addr;
  assign bus.imem_wdata = asm_word;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_mips_debug_unit.sv
// Directed bench for mips_debug_unit: load, step, run/halt, pause, TX
// handshake, mid-load reset and load-address wrap.
module tb_mips_debug_unit;
  import mips_debug_unit_pkg::*;

  localparam int NBITS      = 32;
  localparam int CELDAS_REG = 32;
  localparam int CELDAS_M   = 70;
  localparam int REGS       = 5;
  localparam int IMEM_DEPTH = 16;
  localparam int MEM_AW     = 7;
  localparam int IMEM_AW    = clog2c(IMEM_DEPTH);
  localparam int DUMP_BYTES = (NBITS / 8) * (1 + CELDAS_REG + CELDAS_M);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_debug_unit_if #(.NBITS(NBITS), .REGS(REGS), .IMEM_DEPTH(IMEM_DEPTH),
                       .MEM_AW(MEM_AW)) bus ();

  mips_debug_unit #(
    .NBITS(NBITS), .CELDAS_REG(CELDAS_REG), .CELDAS_M(CELDAS_M),
    .REGS(REGS), .IMEM_DEPTH(IMEM_DEPTH), .MEM_AW(MEM_AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0]         tx_log[$];
  int                 tx_cyc[$];
  logic [7:0]         exp_q[$];
  logic [IMEM_AW-1:0] we_addr_q[$];
  logic [NBITS-1:0]   we_data_q[$];
  int                 tx_delay   = 2;
  int                 tx_cnt     = 0;
  bit                 tx_busy    = 1'b0;
  int                 tx_overlap = 0;
  int                 en_count   = 0;

  // ---------------- environment models ----------------
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    bus.reg_data <= NBITS'(bus.reg_addr);
    bus.mem_data <= 32'h100 + NBITS'(bus.mem_addr);
  end

  // UART TX model: logs each started byte and answers with tx_done later.
  always @(posedge clk) begin
    if (!reset) begin
      tx_busy     = 1'b0;
      bus.tx_done <= 1'b0;
    end else begin
      bus.tx_done <= 1'b0;
      if (bus.tx_start) begin
        if (tx_busy) tx_overlap++;
        tx_log.push_back(bus.tx_data);
        tx_cyc.push_back(cyc);
        tx_busy = 1'b1;
        tx_cnt  = tx_delay;
      end else if (tx_busy) begin
        if (tx_cnt == 0) begin
          bus.tx_done <= 1'b1;
          tx_busy = 1'b0;
        end else begin
          tx_cnt--;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (reset && bus.cpu_enable) en_count++;
    if (reset && bus.imem_we) begin
      we_addr_q.push_back(bus.imem_addr);
      we_data_q.push_back(bus.imem_wdata);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_tx_data"},    64'(bus.tx_data),    0);
    check({pfx, "_tx_start"},   64'(bus.tx_start),   0);
    check({pfx, "_cpu_enable"}, 64'(bus.cpu_enable), 0);
    check({pfx, "_reg_addr"},   64'(bus.reg_addr),   0);
    check({pfx, "_mem_addr"},   64'(bus.mem_addr),   0);
    check({pfx, "_imem_we"},    64'(bus.imem_we),    0);
    check({pfx, "_imem_addr"},  64'(bus.imem_addr),  0);
    check({pfx, "_imem_wdata"}, 64'(bus.imem_wdata), 0);
    check({pfx, "_busy"},       64'(bus.busy),       0);
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    int k = 0;
    while (tx_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_count"}, 64'(tx_log.size()), 64'(n));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (bus.busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, 64'(bus.busy), 0);
  endtask

  // Expected dump: PC, then r[i]=i, then mem[j]=0x100+j, each MSB first.
  task automatic build_dump(input logic [31:0] pc);
    logic [31:0] w;
    exp_q.delete();
    for (int i = 0; i < 1 + CELDAS_REG + CELDAS_M; i++) begin
      if (i == 0)               w = pc;
      else if (i <= CELDAS_REG) w = 32'(i - 1);
      else                      w = 32'h100 + 32'(i - 1 - CELDAS_REG);
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
    end
  endtask

  task automatic compare_dump(input int base, input string tag);
    int bad = 0;
    for (int i = 0; i < DUMP_BYTES; i++)
      if (base + i >= tx_log.size() || tx_log[base + i] !== exp_q[i]) bad++;
    check({tag, "_bytes_bad"}, 64'(bad), 0);
  endtask

  // ---------------- scenarios ----------------
  int tb0, wb0, eb0, ob0, cmd_cyc;

  initial begin
    reset        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.cpu_halt = 1'b0;
    bus.cpu_pc   = 32'h4;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // Load two words, expect two writes and a 'K'.
    tb0 = tx_log.size(); wb0 = we_addr_q.size();
    send_byte(CMD_LOAD); send_byte(8'd2);
    send_word(32'h2001_0005); send_word(32'h8C02_0004);
    wait_bytes(tb0 + 1, 200, "load_ack");
    wait_idle(200, "load");
    check("load_we_count", 64'(we_addr_q.size() - wb0), 2);
    check("load_addr0", 64'(we_addr_q[wb0]), 0);
    check("load_data0", 64'(we_data_q[wb0]), 64'h2001_0005);
    check("load_addr1", 64'(we_addr_q[wb0 + 1]), 1);
    check("load_data1", 64'(we_data_q[wb0 + 1]), 64'h8C02_0004);
    check("load_ack_byte", 64'(tx_log[tb0]), 64'h4B);

    // Zero-length load.
    tb0 = tx_log.size(); wb0 = we_addr_q.size();
    send_byte(CMD_LOAD); send_byte(8'd0);
    repeat (5) @(negedge clk);
    check("load0_busy", 64'(bus.busy), 0);
    check("load0_we", 64'(we_addr_q.size() - wb0), 0);
    check("load0_tx", 64'(tx_log.size() - tb0), 0);

    // Single step.
    build_dump(32'h4);
    eb0 = en_count; tb0 = tx_log.size();
    send_byte(CMD_STEP);
    wait_bytes(tb0 + DUMP_BYTES, 6000, "step");
    wait_idle(100, "step");
    check("step_enable_cycles", 64'(en_count - eb0), 1);
    compare_dump(tb0, "step");
    check("step_pc_lsb", 64'(tx_log[tb0 + 3]), 64'h04);
    check("step_r1_lsb", 64'(tx_log[tb0 + 11]), 64'h01);
    check("step_last_b0", 64'(tx_log[tb0 + DUMP_BYTES - 4]), 64'h00);
    check("step_last_b1", 64'(tx_log[tb0 + DUMP_BYTES - 3]), 64'h00);
    check("step_last_b2", 64'(tx_log[tb0 + DUMP_BYTES - 2]), 64'h01);
    check("step_last_b3", 64'(tx_log[tb0 + DUMP_BYTES - 1]), 64'h45);

    // Run, halt seen at cycle 50: enabled cycles 1..49.
    bus.cpu_pc = 32'h0000_00C8;
    build_dump(32'h0000_00C8);
    eb0 = en_count; tb0 = tx_log.size();
    send_byte(CMD_RUN);
    repeat (48) @(negedge clk);
    bus.cpu_halt = 1'b1;
    wait_bytes(tb0 + DUMP_BYTES, 6000, "halt");
    wait_idle(100, "halt");
    bus.cpu_halt = 1'b0;
    check("halt_enable_cycles", 64'(en_count - eb0), 49);
    compare_dump(tb0, "halt");

    // Run, stray byte ignored, then pause.
    eb0 = en_count; tb0 = tx_log.size();
    send_byte(CMD_RUN);
    repeat (8) @(negedge clk);
    send_byte(8'h58);
    check("run_stray_busy", 64'(bus.busy), 1);
    check("run_stray_enable", 64'(bus.cpu_enable), 1);
    send_byte(CMD_PAUSE);
    wait_bytes(tb0 + DUMP_BYTES, 6000, "pause");
    wait_idle(100, "pause");
    check("pause_enable_cycles", 64'(en_count - eb0), 12);
    compare_dump(tb0, "pause");

    // Halt and 'P' in the same cycle: one dump, no enable on that cycle.
    eb0 = en_count; tb0 = tx_log.size();
    send_byte(CMD_RUN);
    repeat (3) @(negedge clk);
    bus.cpu_halt = 1'b1;
    bus.rx_data  = CMD_PAUSE;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    wait_bytes(tb0 + DUMP_BYTES, 6000, "both");
    wait_idle(100, "both");
    bus.cpu_halt = 1'b0;
    repeat (20) @(negedge clk);
    check("both_total_bytes", 64'(tx_log.size() - tb0), 64'(DUMP_BYTES));
    check("both_enable_cycles", 64'(en_count - eb0), 4);
    compare_dump(tb0, "both");

    // Slow TX: handshake discipline, command latency, bytes dropped mid-dump.
    tx_delay = 1000;
    eb0 = en_count; tb0 = tx_log.size(); wb0 = we_addr_q.size(); ob0 = tx_overlap;
    cmd_cyc = cyc;
    send_byte(CMD_DUMP);
    wait_bytes(tb0 + 5, 8000, "slow_first");
    check("dump_latency", 64'(tx_cyc[tb0] - cmd_cyc), 3);
    send_byte(CMD_LOAD); send_byte(8'd3); send_byte(CMD_STEP);
    send_byte(CMD_RUN);  send_byte(CMD_DUMP);
    tx_delay = 2;
    wait_bytes(tb0 + DUMP_BYTES, 20000, "slow");
    wait_idle(100, "slow");
    repeat (20) @(negedge clk);
    check("slow_overlap", 64'(tx_overlap - ob0), 0);
    check("slow_total_bytes", 64'(tx_log.size() - tb0), 64'(DUMP_BYTES));
    check("slow_enable_cycles", 64'(en_count - eb0), 0);
    check("slow_we", 64'(we_addr_q.size() - wb0), 0);
    compare_dump(tb0, "slow");

    // Reset after 3 of 4 bytes of word 0.
    wb0 = we_addr_q.size(); tb0 = tx_log.size();
    send_byte(CMD_LOAD); send_byte(8'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("midrst");
    reset = 1'b1;
    @(negedge clk);
    check("midrst_we", 64'(we_addr_q.size() - wb0), 0);
    check("midrst_tx", 64'(tx_log.size() - tb0), 0);
    send_byte(CMD_LOAD); send_byte(8'd1);
    send_word(32'hAABB_CCDD);
    wait_bytes(tb0 + 1, 200, "reload_ack");
    wait_idle(200, "reload");
    check("reload_we_count", 64'(we_addr_q.size() - wb0), 1);
    check("reload_addr", 64'(we_addr_q[wb0]), 0);
    check("reload_data", 64'(we_data_q[wb0]), 64'hAABB_CCDD);
    check("reload_ack_byte", 64'(tx_log[tb0]), 64'h4B);

    // IMEM_DEPTH+1 words: last write wraps to address 0.
    wb0 = we_addr_q.size(); tb0 = tx_log.size();
    send_byte(CMD_LOAD); send_byte(8'(IMEM_DEPTH + 1));
    for (int k = 0; k <= IMEM_DEPTH; k++) send_word(32'hA000_0000 + 32'(k));
    wait_bytes(tb0 + 1, 400, "wrap_ack");
    wait_idle(400, "wrap");
    check("wrap_we_count", 64'(we_addr_q.size() - wb0), 64'(IMEM_DEPTH + 1));
    check("wrap_first_data", 64'(we_data_q[wb0]), 64'hA000_0000);
    check("wrap_top_addr", 64'(we_addr_q[wb0 + IMEM_DEPTH - 1]), 64'(IMEM_DEPTH - 1));
    check("wrap_last_addr", 64'(we_addr_q[wb0 + IMEM_DEPTH]), 0);
    check("wrap_last_data", 64'(we_data_q[wb0 + IMEM_DEPTH]), 64'hA000_0000 + 64'(IMEM_DEPTH));
    check("wrap_ack_byte", 64'(tx_log[tb0]), 64'h4B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

endmodule
